// File: rtl/distortion_pipe.sv
// distortion_pipe: three-stage signed waveshaper with per-frame mode select.
//   S1: channel tag, frame mode capture, gain (x1/x2/x4/x8) into DATA_W+4 bits
//   S2: sign/magnitude split and region select against the mode threshold
//   S3: piecewise compression, saturation, clip flag
// Ports:
//   clk, rst_n            clock, async active-low reset
//   mode                  00 clean, 01 light, 10 normal, 11 heavy
//   in_valid/in_ready     input handshake, in_data sample
//   out_valid/out_ready   output handshake, out_data/out_ch/out_clip
//   clip_clr, clip_cnt    synchronous clear / saturating clipped-sample count
module distortion_pipe #(
  parameter int DATA_W    = 16,
  parameter int NCH       = 2,
  parameter int THR_LIGHT = 20000,
  parameter int THR_NORM  = 16000,
  parameter int THR_HEAVY = 12000,
  parameter int CNT_W     = 16,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_clip,
  input  logic              clip_clr,
  output logic [CNT_W-1:0]  clip_cnt
);

  localparam int EW = DATA_W + 4;
  typedef logic [EW-1:0] ext_t;

  localparam ext_t T_L  = ext_t'(THR_LIGHT);
  localparam ext_t T_N  = ext_t'(THR_NORM);
  localparam ext_t T_H  = ext_t'(THR_HEAVY);
  localparam ext_t MAXP = ext_t'((1 << (DATA_W - 1)) - 1);
  localparam ext_t MAXN = ext_t'(1 << (DATA_W - 1));
  localparam logic [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic ext_t thr(input logic [1:0] m);
    case (m)
      2'b01:   return T_L;
      2'b10:   return T_N;
      2'b11:   return T_H;
      default: return '0;
    endcase
  endfunction

  logic              en, acc;
  logic [CH_W-1:0]   ch_cnt;
  logic [1:0]        mode_act, mode_eff;
  ext_t              gain;

  // S1 registers
  logic              v1;
  logic [CH_W-1:0]   ch1;
  logic [1:0]        mode1;
  ext_t              g1;
  logic [DATA_W-1:0] raw1;
  ext_t              mag1, t1;
  logic [1:0]        reg1;

  // S2 registers
  logic              v2, s2, byp2;
  logic [CH_W-1:0]   ch2;
  ext_t              a2, t2;
  logic [1:0]        reg2;
  logic [DATA_W-1:0] raw2;

  // S3 combinational result
  ext_t              mag3;
  logic [DATA_W-1:0] y3;
  logic              sat3, clip3;

  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;
  assign acc      = in_valid && in_ready;

  // A channel-0 sample uses the mode present at its own acceptance; the
  // remaining channels of the frame reuse that captured value.
  assign mode_eff = (ch_cnt == '0) ? mode : mode_act;
  assign gain     = ext_t'({{4{in_data[DATA_W-1]}}, in_data}) << mode_eff;

  // Magnitude at EW bits cannot overflow: |x8 * min| = 2^(DATA_W+2) < 2^EW.
  assign mag1 = g1[EW-1] ? (ext_t'(0) - g1) : g1;
  assign t1   = thr(mode1);
  assign reg1 = (mag1 <= t1)        ? 2'd1 :
                (mag1 <= (t1 << 1)) ? 2'd2 : 2'd3;

  always_comb begin
    mag3  = a2;
    y3    = '0;
    sat3  = 1'b0;
    clip3 = 1'b0;
    case (reg2)
      2'd2:    mag3 = t2 + ((a2 - t2) >> 1);
      2'd3:    mag3 = t2 + (t2 >> 1) + ((a2 - (t2 << 1)) >> 2);
      default: mag3 = a2;
    endcase
    if (byp2) begin
      y3 = raw2;
    end else begin
      if (s2) begin
        if (mag3 > MAXN) begin
          y3   = Y_MIN;
          sat3 = 1'b1;
        end else begin
          y3 = {DATA_W{1'b0}} - mag3[DATA_W-1:0];
        end
      end else begin
        if (mag3 > MAXP) begin
          y3   = Y_MAX;
          sat3 = 1'b1;
        end else begin
          y3 = mag3[DATA_W-1:0];
        end
      end
      clip3 = (reg2 == 2'd3) || sat3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt    <= '0;
      mode_act  <= 2'b00;
      v1        <= 1'b0;
      ch1       <= '0;
      mode1     <= 2'b00;
      g1        <= '0;
      raw1      <= '0;
      v2        <= 1'b0;
      s2        <= 1'b0;
      byp2      <= 1'b1;
      ch2       <= '0;
      a2        <= '0;
      t2        <= '0;
      reg2      <= 2'd1;
      raw2      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_clip  <= 1'b0;
    end else if (en) begin
      if (acc) begin
        ch_cnt <= (ch_cnt == CH_W'(NCH - 1)) ? '0 : ch_cnt + 1'b1;
        if (ch_cnt == '0) mode_act <= mode;
      end
      v1        <= acc;
      ch1       <= ch_cnt;
      mode1     <= mode_eff;
      g1        <= gain;
      raw1      <= in_data;
      v2        <= v1;
      s2        <= g1[EW-1];
      byp2      <= (mode1 == 2'b00);
      ch2       <= ch1;
      a2        <= mag1;
      t2        <= t1;
      reg2      <= reg1;
      raw2      <= raw1;
      out_valid <= v2;
      out_data  <= y3;
      out_ch    <= ch2;
      out_clip  <= clip3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt <= '0;
    end else if (clip_clr) begin
      clip_cnt <= '0;
    end else if (out_valid && out_ready && out_clip && !(&clip_cnt)) begin
      clip_cnt <= clip_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_distortion_pipe.sv
// Directed bench for distortion_pipe: hand-computed vectors, immediate asserts.
module tb_distortion_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [0:0]  out_ch;
  logic        out_clip;
  logic        clip_clr;
  logic [15:0] clip_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  distortion_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_clip (out_clip),
    .clip_clr (clip_clr),
    .clip_cnt (clip_cnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  // Called at a negedge; returns at the negedge after the output was consumed.
  task automatic send1(input string tag, input logic [1:0] m, input int d,
                       input int exp_d, input int exp_clip, input int exp_ch,
                       input logic clr);
    mode = m; in_data = 16'(d); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, int'(out_valid), 0);
    @(negedge clk);
    check({tag, "_lat2"}, int'(out_valid), 0);
    @(negedge clk);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_data"},  sdata(), exp_d);
    check({tag, "_clip"},  int'(out_clip), exp_clip);
    check({tag, "_ch"},    int'(out_ch), exp_ch);
    clip_clr = clr;
    @(negedge clk);
    clip_clr = 1'b0;
    check({tag, "_drain"}, int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mode = 2'b00; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; clip_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", sdata(), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_clip", int'(out_clip), 0);
    check("rst_clip_cnt", int'(clip_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 15000*2=30000, region 2 of T=20000: 20000+5000
    send1("light_15000", 2'b01, 15000, 25000, 0, 0, 1'b0);
    // mode switched to 11 mid-frame: ch1 still x2, 2000 in region 1
    send1("modechg_ch1", 2'b11, 1000, 2000, 0, 1, 1'b0);
    // now ch0 picks up mode 11: 64000 -> 12000+6000+10000
    send1("heavy_8000", 2'b11, 8000, 28000, 1, 0, 1'b0);
    check("cnt_after_heavy", int'(clip_cnt), 1);
    send1("heavy_min", 2'b11, -32768, -32768, 1, 1, 1'b0);
    check("cnt_after_min", int'(clip_cnt), 2);
    // 20000 with T=16000: 16000+2000
    send1("norm_5000", 2'b10, 5000, 18000, 0, 0, 1'b0);
    send1("norm_neg5000", 2'b10, -5000, -18000, 0, 1, 1'b0);
    send1("clean_min", 2'b00, -32768, -32768, 0, 0, 1'b0);
    send1("clean_max", 2'b00, 32767, 32767, 0, 1, 1'b0);
    check("cnt_after_clean", int'(clip_cnt), 2);
    // 262136 -> 77534 -> saturates high
    send1("heavy_max", 2'b11, 32767, 32767, 1, 0, 1'b0);
    send1("heavy_r1", 2'b11, 1000, 8000, 0, 1, 1'b0);
    check("cnt_after_max", int'(clip_cnt), 3);

    // Stall: three samples in flight, out_ready low for 5 cycles
    out_ready = 1'b0; mode = 2'b01; in_valid = 1'b1; in_data = 16'd100;
    @(negedge clk); in_data = 16'd200;
    @(negedge clk); in_data = 16'd300;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", sdata(), 200);
      check("stall_ch", int'(out_ch), 0);
      check("stall_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drain1_valid", int'(out_valid), 1);
    check("drain1_data", sdata(), 400);
    check("drain1_ch", int'(out_ch), 1);
    @(negedge clk);
    check("drain2_valid", int'(out_valid), 1);
    check("drain2_data", sdata(), 600);
    check("drain2_ch", int'(out_ch), 0);
    @(negedge clk);
    check("drain_empty", int'(out_valid), 0);

    // ch1, mode 01: 60000 -> 35000 saturates; clear lands on the same edge
    check("cnt_before_clr", int'(clip_cnt), 3);
    send1("clr_clip", 2'b01, 30000, 32767, 1, 1, 1'b1);
    check("cnt_after_clr", int'(clip_cnt), 0);

    send1("pre_rst_clip", 2'b11, 8000, 28000, 1, 0, 1'b0);
    send1("pre_rst_ch1", 2'b11, 1000, 8000, 0, 1, 1'b0);
    check("cnt_pre_rst", int'(clip_cnt), 1);

    // One ch0 sample held at the output, then reset mid-frame
    out_ready = 1'b0; mode = 2'b01; in_data = 16'd1000; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("held_valid", int'(out_valid), 1);
    check("held_data", sdata(), 2000);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_data", sdata(), 0);
    check("midrst_ch", int'(out_ch), 0);
    check("midrst_clip", int'(out_clip), 0);
    check("midrst_cnt", int'(clip_cnt), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    send1("post_rst_ch0", 2'b10, 5000, 18000, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/distortion_pipe.md
DISTORTION_PIPE -- requirements
Module: distortion_pipe

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DATA_W, 16, sample width, signed two's complement.
- NCH, 2, channels per frame, time-multiplexed in order 0..NCH-1.
- THR_LIGHT, 20000, region threshold T for mode 01.
- THR_NORM, 16000, T for mode 10.
- THR_HEAVY, 12000, T for mode 11.
- CNT_W, 16, clip counter width.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- mode, in, 2: 00 clean, 01 light, 10 normal, 11 heavy.
- in_valid, in, 1, input sample valid.
- in_ready, out, 1, input accepted when in_valid && in_ready.
- in_data, in, DATA_W, input sample.
- out_valid, out, 1, output sample valid.
- out_ready, in, 1, downstream accepts when out_valid && out_ready.
- out_data, out, DATA_W, shaped sample.
- out_ch, out, max(1,clog2(NCH)), channel index of out_data.
- out_clip, out, 1, out_data was compressed in region 3 or saturated.
- clip_clr, in, 1, synchronous clear of clip_cnt.
- clip_cnt, out, CNT_W, saturating count of clipped output samples.
REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The datapath SHALL be a 3-stage pipeline: S1 gain; S2 sign/magnitude/region select; S3 shaping and saturation.
REQ-005 Latency SHALL be exactly 3 cycles from input handshake to out_valid when no stall occurs; throughput SHALL be one sample per cycle.
REQ-006 The pipeline SHALL stall as a unit: in_ready = !(out_valid && !out_ready); stalled stages SHALL hold their contents unchanged.
REQ-007 out_data, out_ch and out_clip SHALL stay stable while out_valid && !out_ready.
REQ-008 An input channel counter SHALL assign channels 0..NCH-1 in accept order, wrapping from NCH-1 to 0; the channel index SHALL travel with the sample to out_ch.
REQ-009 mode SHALL be sampled into an active-mode register only on acceptance of a channel-0 sample; all channels of a frame SHALL use the same mode.
REQ-010 S1 gain SHALL be: 00 x1, 01 x2, 10 x4, 11 x8, sign-extended to DATA_W+4 bits with no overflow.
REQ-011 Mode 00 SHALL bypass shaping: out_data = in_data and out_clip = 0.
REQ-012 For other modes, with a = |x| computed at DATA_W+4 bits and s = sign(x):
- region 1, a <= T: y = x.
- region 2, T < a <= 2T: y = s*(T + ((a-T)>>1)).
- region 3, a > 2T: y = s*(T + (T>>1) + ((a-2T)>>2)).
REQ-013 y SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-014 out_clip SHALL be 1 when region 3 applied or saturation occurred, otherwise 0.
REQ-015 clip_cnt SHALL increment by 1 on each output handshake with out_clip=1 and SHALL saturate at 2^CNT_W-1.
REQ-016 When clip_clr=1, clip_cnt SHALL become 0 on the next edge; this SHALL override a simultaneous increment.
REQ-017 The most negative input SHALL be handled without magnitude overflow.

Reset
REQ-018 Asserting rst_n=0 at any time, including mid-frame or during a stall, SHALL immediately clear the following: all stage valids, out_valid, out_data, out_ch, out_clip, clip_cnt, the channel counter, and the active mode (to 00).
REQ-019 During reset in_ready SHALL be 1. After release, the first accepted sample SHALL be channel 0.

Verification
REQ-020 The bench SHALL cover:
- Mode 01, in 15000 -> out 25000, clip 0, 3 cycles later. Mode 10, in 5000 -> out 18000.
- Mode 11, in 8000 -> out 28000, clip 1. Mode 11, in -32768 -> out -32768, clip 1, clip_cnt +1.
- Mode 00, in -32768 and 32767 -> outputs identical, clip 0, clip_cnt unchanged.
- out_ready held 0 for 5 cycles with 3 samples in flight -> in_ready 0, outputs stable, no loss or duplication, order and out_ch 0,1,0 preserved.
- mode changed 01->11 between ch0 and ch1 -> ch1 still uses mode 01; next ch0 uses 11.
- clip_clr coincident with a clipped handshake -> clip_cnt=0. rst_n pulsed mid-frame -> all outputs 0, next accept is ch0.
